dsp_mac_ex_unit: RTL and testbench



---
 rtl/dsp_mac_ex_unit_if.sv | 37 +++
 rtl/dsp_mac_ex_unit.sv | 163 ++++++++++++++++
 tb/tb_dsp_mac_ex_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_ex_unit_if.sv
// Handshake and write-back bundle between the pipeline control unit and the DSP MAC EX unit.
// sat_flag exists only when DSP_SAT_EN is defined.
interface dsp_mac_ex_unit_if #(
   parameter int ACC_W = 64
);
   logic             start;
   logic [2:0]       op;
   logic [31:0]      rs1_val;
   logic [31:0]      rs2_val;
   logic [4:0]       rd_in;
   logic             ex_stall;
   logic             ex_flush;
   logic             busy;
   logic             result_valid;
   logic [31:0]      result;
   logic [4:0]       result_rd;
   logic [ACC_W-1:0] acc_out;
`ifdef DSP_SAT_EN
   logic             sat_flag;
`endif

   modport master (
      output start, op, rs1_val, rs2_val, rd_in, ex_stall, ex_flush,
      input  busy, result_valid, result, result_rd, acc_out
`ifdef DSP_SAT_EN
      , input sat_flag
`endif
   );

   modport slave (
      input  start, op, rs1_val, rs2_val, rd_in, ex_stall, ex_flush,
      output busy, result_valid, result, result_rd, acc_out
`ifdef DSP_SAT_EN
      , output sat_flag
`endif
   );
endinterface

// File: rtl/dsp_mac_ex_unit.sv
// Iterative signed MUL/MULH/MAC/MSU EX unit with private accumulator; DSP_SAT_EN enables saturating MAC/MSU and sat_flag.
// Multiply ops take 32/BITS_PER_CYCLE cycles plus one WRITE cycle; WRITE holds under ex_stall, ex_flush kills at any time.
module dsp_mac_ex_unit #(
   parameter int BITS_PER_CYCLE = 8,
   parameter int ACC_W          = 64
) (
   input  logic             clk,
   input  logic             rst,
   dsp_mac_ex_unit_if.slave ex
);
   localparam int N     = 32 / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_MULH = 3'b001;
   localparam logic [2:0] OP_MAC  = 3'b010;
   localparam logic [2:0] OP_MSU  = 3'b011;
   localparam logic [2:0] OP_CLR  = 3'b100;
   localparam logic [2:0] OP_RDH  = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MUL   = 2'b01,
      WRITE = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [4:0]       rd_q;
   logic [63:0]      mcand;
   logic [31:0]      mplier;
   logic             neg_q;
   logic [63:0]      pp;
   logic [ACC_W-1:0] acc;

   logic             accept;
   logic             last_iter;
   logic             commit;
   logic [31:0]      mag_a;
   logic [31:0]      mag_b;
   logic [63:0]      pp_sum;
   logic signed [63:0]      prod_s;
   logic signed [ACC_W-1:0] prod_x;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] diff;
   logic [ACC_W-1:0] acc_new;
   logic [31:0]      res;
`ifdef DSP_SAT_EN
   logic             sat;
   localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   assign accept    = (state == IDLE) && ex.start && !ex.ex_flush && !ex.ex_stall;
   assign last_iter = (cnt == CNT_W'(N - 1));
   assign commit    = (state == WRITE) && !ex.ex_stall && !ex.ex_flush;

   // Magnitudes feed an unsigned shift-add; the sign is re-applied on the last iteration.
   assign mag_a  = ex.rs1_val[31] ? (32'd0 - ex.rs1_val) : ex.rs1_val;
   assign mag_b  = ex.rs2_val[31] ? (32'd0 - ex.rs2_val) : ex.rs2_val;
   assign pp_sum = pp + (mcand * 64'(mplier[BITS_PER_CYCLE-1:0]));

   assign prod_s = $signed(pp);
   assign prod_x = ACC_W'(prod_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg_q  <= 1'b0;
         pp     <= '0;
         acc    <= '0;
      end else begin
         state <= state_nxt;
         if (ex.ex_flush) begin
            cnt <= '0;
         end else if (accept) begin
            op_q   <= ex.op;
            rd_q   <= ex.rd_in;
            mcand  <= {32'd0, mag_a};
            mplier <= mag_b;
            neg_q  <= ex.rs1_val[31] ^ ex.rs2_val[31];
            pp     <= '0;
            cnt    <= '0;
         end else if (state == MUL) begin
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= last_iter ? '0 : cnt + CNT_W'(1);
            pp     <= (last_iter && neg_q) ? (64'd0 - pp_sum) : pp_sum;
         end
         if (commit) begin
            acc <= acc_new;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (ex.ex_flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = ex.op[2] ? WRITE : MUL;
            MUL:     if (last_iter) state_nxt = WRITE;
            WRITE:   if (!ex.ex_stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      sum     = acc + prod_x;
      diff    = acc - prod_x;
      acc_new = acc;
`ifdef DSP_SAT_EN
      sat     = 1'b0;
`endif
      case (op_q)
         OP_MAC:  acc_new = sum;
         OP_MSU:  acc_new = diff;
         OP_CLR:  acc_new = '0;
         default: acc_new = acc;
      endcase
`ifdef DSP_SAT_EN
      // Overflow clamps toward the accumulator's sign, which is the direction it ran off in.
      if ((op_q == OP_MAC) && (acc[ACC_W-1] == prod_x[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
         sat = 1'b1;
      if ((op_q == OP_MSU) && (acc[ACC_W-1] != prod_x[ACC_W-1]) && (diff[ACC_W-1] != acc[ACC_W-1]))
         sat = 1'b1;
      if (sat)
         acc_new = acc[ACC_W-1] ? SMIN : SMAX;
`endif
   end

   always_comb begin
      res = '0;
      if (state == WRITE) begin
         case (op_q)
            OP_MUL:         res = pp[31:0];
            OP_MULH:        res = pp[63:32];
            OP_MAC, OP_MSU: res = acc_new[31:0];
            OP_CLR:         res = acc[31:0];
            OP_RDH:         res = acc[63:32];
            default:        res = '0;
         endcase
      end
   end

   assign ex.busy         = (state != IDLE);
   assign ex.result_valid = (state == WRITE);
   assign ex.result       = res;
   assign ex.result_rd    = rd_q;
   assign ex.acc_out      = acc;
`ifdef DSP_SAT_EN
   assign ex.sat_flag     = (state == WRITE) && sat;
`endif
endmodule

// File: tb/tb_dsp_mac_ex_unit.sv
// Directed bench for dsp_mac_ex_unit: literal per-op expectations plus a per-cycle behavioural model of results and accumulator.
module tb_dsp_mac_ex_unit;
   localparam int BPC = 8;
   localparam int N   = 32 / BPC;

   localparam logic [2:0] MUL  = 3'b000;
   localparam logic [2:0] MULH = 3'b001;
   localparam logic [2:0] MAC  = 3'b010;
   localparam logic [2:0] MSU  = 3'b011;
   localparam logic [2:0] CLR  = 3'b100;
   localparam logic [2:0] RDH  = 3'b101;

`ifdef DSP_SAT_EN
   localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
   localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dsp_mac_ex_unit_if #(.ACC_W(64)) bus ();

   dsp_mac_ex_unit #(.BITS_PER_CYCLE(BPC), .ACC_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .ex  (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Architectural meaning of each op, straight from signed integer arithmetic.
   function automatic void model_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [63:0] acc, output logic [31:0] res,
                                      output logic [63:0] nacc, output logic sat);
      longint p;
      logic signed [65:0] w;
      p    = longint'($signed(a)) * longint'($signed(b));
      res  = '0;
      nacc = acc;
      sat  = 1'b0;
      case (o)
         MUL:  res = p[31:0];
         MULH: res = p[63:32];
         MAC, MSU: begin
            if (o == MAC) w = 66'($signed(acc)) + 66'(p);
            else          w = 66'($signed(acc)) - 66'(p);
`ifdef DSP_SAT_EN
            if (w > SMAX) begin w = SMAX; sat = 1'b1; end
            else if (w < SMIN) begin w = SMIN; sat = 1'b1; end
`endif
            nacc = w[63:0];
            res  = w[31:0];
         end
         CLR: begin res = acc[31:0]; nacc = '0; end
         RDH: res = acc[63:32];
         default: res = '0;
      endcase
   endfunction

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic [63:0] acc;
      logic        sat;
   } exp_t;

   exp_t        q[$];
   logic [63:0] exp_acc = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_acc = '0;
         q.delete();
      end else begin
         check("model_acc", bus.acc_out, exp_acc);
         check("model_busy", 64'(bus.busy), 64'(q.size() != 0));
         if (bus.result_valid) begin
            if (q.size() == 0) begin
               check("model_unexpected_valid", 64'(bus.result_valid), 64'd0);
            end else begin
               check("model_result", 64'(bus.result), 64'(q[0].res));
               check("model_rd", 64'(bus.result_rd), 64'(q[0].rd));
`ifdef DSP_SAT_EN
               check("model_sat", 64'(bus.sat_flag), 64'(q[0].sat));
`endif
            end
         end
         if (bus.ex_flush) begin
            if (bus.busy && q.size() != 0) void'(q.pop_front());
         end else if (bus.result_valid && !bus.ex_stall) begin
            if (q.size() != 0) begin
               exp_acc = q[0].acc;
               void'(q.pop_front());
            end
         end else if (bus.start && !bus.busy && !bus.ex_stall) begin
            model_exec(bus.op, bus.rs1_val, bus.rs2_val, exp_acc, e.res, e.acc, e.sat);
            e.rd = bus.rd_in;
            q.push_back(e);
         end
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input int hold, input logic [31:0] exp_res,
                         input string name);
      int bcnt;
      int vcnt;
      int base;
      bcnt = 0;
      vcnt = 0;
      base = o[2] ? 1 : N + 1;
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.op      = o;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_in   = d;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.ex_stall = (hold > 0);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.result_valid) begin
            vcnt++;
            check({name, "_result"}, 64'(bus.result), 64'(exp_res));
            check({name, "_rd"}, 64'(bus.result_rd), 64'(d));
            if (!bus.ex_stall) break;
            if (vcnt == hold) begin
               @(posedge clk); #1;
               bus.ex_stall = 1'b0;
            end
         end
      end
      bus.ex_stall = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_busy_cycles"}, 64'(bcnt), 64'(base + hold));
      check({name, "_valid_cycles"}, 64'(vcnt), 64'(hold + 1));
      check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check({name, "_idle_valid"}, 64'(bus.result_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.start    = 1'b0;
      bus.op       = '0;
      bus.rs1_val  = '0;
      bus.rs2_val  = '0;
      bus.rd_in    = '0;
      bus.ex_stall = 1'b0;
      bus.ex_flush = 1'b0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_valid", 64'(bus.result_valid), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_rd", 64'(bus.result_rd), 64'd0);
      check("rst_acc", bus.acc_out, 64'd0);

      run_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 32'hFFFF_FFEB, "mul");
      check("mul_acc", bus.acc_out, 64'd0);

      run_op(MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 0, 32'h4000_0000, "mulh");
      run_op(MAC, 32'd100, 32'd200, 5'd7, 0, 32'd20000, "mac1");
      run_op(MAC, 32'd100, 32'd200, 5'd7, 0, 32'd40000, "mac2");
      check("mac2_acc", bus.acc_out, 64'd40000);
      run_op(MSU, 32'd1, 32'd40000, 5'd8, 0, 32'd0, "msu");
      check("msu_acc", bus.acc_out, 64'd0);

      run_op(MAC, 32'd2, 32'd3, 5'd0, 3, 32'd6, "mac_stall");
      check("stall_acc", bus.acc_out, 64'd6);

      // Flush during the third multiply iteration.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MAC; bus.rs1_val = 32'd5; bus.rs2_val = 32'd5; bus.rd_in = 5'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.ex_flush = 1'b1;
      @(posedge clk); #1;
      bus.ex_flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("flush_no_valid", 64'(bus.result_valid), 64'd0);
      end
      check("flush_acc", bus.acc_out, 64'd6);

      @(posedge clk); #1;
      bus.start = 1'b1; bus.ex_flush = 1'b1; bus.op = MAC; bus.rs1_val = 32'd4; bus.rs2_val = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.ex_flush = 1'b0;
      @(negedge clk);
      check("start_flush_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("start_flush_busy2", 64'(bus.busy), 64'd0);

      // Reset in the middle of a multiply.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MAC; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9; bus.rd_in = 5'd10;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_valid", 64'(bus.result_valid), 64'd0);
      check("midrst_result", 64'(bus.result), 64'd0);
      check("midrst_rd", 64'(bus.result_rd), 64'd0);
      check("midrst_acc", bus.acc_out, 64'd0);

      run_op(MAC, 32'd100, 32'd200, 5'd11, 0, 32'd20000, "mac3");
      run_op(MAC, 32'd100, 32'd200, 5'd11, 0, 32'd40000, "mac4");
      run_op(CLR, 32'd0, 32'd0, 5'd12, 0, 32'd40000, "clracc");
      check("clracc_acc", bus.acc_out, 64'd0);

      // Walk the accumulator up to 0x7FFFFFFFFFFFFFF0.
      run_op(MAC, 32'h8000_0000, 32'h8000_0000, 5'd13, 0, 32'h0000_0000, "pre1");
      run_op(MAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd13, 0, 32'h0000_0001, "pre2");
      run_op(MAC, 32'h7FFF_FFF8, 32'd2, 5'd13, 0, 32'hFFFF_FFF1, "pre3");
      run_op(MSU, 32'd1, 32'd1, 5'd13, 0, 32'hFFFF_FFF0, "pre4");
      check("pre_acc", bus.acc_out, 64'h7FFF_FFFF_FFFF_FFF0);

`ifdef DSP_SAT_EN
      run_op(MAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd14, 0, 32'hFFFF_FFFF, "mac_sat");
      check("sat_acc", bus.acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
      run_op(RDH, 32'd0, 32'd0, 5'd15, 0, 32'h7FFF_FFFF, "rdacch");
`else
      run_op(MAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd14, 0, 32'hFFFF_FFF1, "mac_wrap");
      check("wrap_acc", bus.acc_out, 64'hBFFF_FFFE_FFFF_FFF1);
      check("wrap_acc_sign", 64'(bus.acc_out[63]), 64'd1);
      run_op(RDH, 32'd0, 32'd0, 5'd15, 0, 32'hBFFF_FFFE, "rdacch");
`endif
      run_op(3'b110, 32'd5, 32'd5, 5'd16, 0, 32'd0, "illegal");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
